// File: rtl/corelet_ctrl.sv
// -----------------------------------------------------------------------------
// corelet_ctrl : instruction sequencer for the corelet.
//
// One start request runs a full job:
//   load `row` weight words from xmem into L0,
//   issue the kernel-load opcode,
//   flush for `col` cycles,
//   stream `a_len` activation vectors from xmem into L0,
//   issue the execute opcode,
//   drain the output FIFO into consecutive pmem addresses.
//
// Ports
//   clk, reset       : clock, synchronous active-low reset
//   start            : one-cycle job request, honoured only while idle
//   acc_en           : job config, drives inst[33] on pmem write cycles
//   w_base, a_base   : job config, xmem base addresses
//   a_len            : job config, number of activation vectors
//   p_base           : job config, pmem base address
//   ofifo_valid      : corelet output FIFO holds a readable row
//   inst             : registered 34-bit corelet/SRAM instruction word
//   busy             : registered, high whenever a job is in progress
//   done             : registered one-cycle completion pulse
//
// Every output is the registered image of the decision taken in the previous
// cycle, so the whole inst stream lags the state register by one clock.
// -----------------------------------------------------------------------------
module corelet_ctrl #(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int addr_bw = 11,
    parameter int len_bw  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               acc_en,
    input  logic [addr_bw-1:0] w_base,
    input  logic [addr_bw-1:0] a_base,
    input  logic [len_bw-1:0]  a_len,
    input  logic [addr_bw-1:0] p_base,
    input  logic               ofifo_valid,
    output logic [33:0]        inst,
    output logic               busy,
    output logic               done
);

    localparam int CW = len_bw + 1;
    // Both SRAM chip enables high, everything else zero.
    localparam logic [33:0] IDLE_WORD = 34'h0100080;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_W_FILL  = 3'd1,
        ST_W_LOAD  = 3'd2,
        ST_W_FLUSH = 3'd3,
        ST_A_FILL  = 3'd4,
        ST_A_EXEC  = 3'd5,
        ST_DRAIN   = 3'd6,
        ST_DONE    = 3'd7
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [CW-1:0]      rd_cnt_q, rd_cnt_d;
    logic [CW-1:0]      wr_cnt_q, wr_cnt_d;
    logic               rd_pend_q, rd_pend_d;
    logic               acc_en_q, acc_en_d;
    logic [addr_bw-1:0] w_base_q, w_base_d;
    logic [addr_bw-1:0] a_base_q, a_base_d;
    logic [addr_bw-1:0] p_base_q, p_base_d;
    logic [len_bw-1:0]  a_len_q, a_len_d;
    logic [33:0]        inst_q, inst_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Fill phases share one datapath; these select weight or activation config.
    logic [addr_bw-1:0] fill_base_s;
    logic [CW-1:0]      fill_len_s;
    logic [addr_bw-1:0] fill_addr_s;
    logic [addr_bw-1:0] pmem_addr_s;
    logic [CW-1:0]      a_len_ext_s;

    assign inst = inst_q;
    assign busy = busy_q;
    assign done = done_q;

    // Address arithmetic for xmem fill reads and pmem drain writes (wraps mod 2^addr_bw).
    always_comb begin
        a_len_ext_s = CW'(a_len_q);
        if (state_q == ST_A_FILL) begin
            fill_base_s = a_base_q;
            fill_len_s  = a_len_ext_s;
        end else begin
            fill_base_s = w_base_q;
            fill_len_s  = CW'(row);
        end
        fill_addr_s = fill_base_s + addr_bw'(cnt_q);
        pmem_addr_s = p_base_q + addr_bw'(wr_cnt_q);
    end

    // Next-state, counter and instruction-word decision for the coming cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        rd_pend_d = rd_pend_q;
        acc_en_d  = acc_en_q;
        w_base_d  = w_base_q;
        a_base_d  = a_base_q;
        p_base_d  = p_base_q;
        a_len_d   = a_len_q;
        inst_d    = IDLE_WORD;
        busy_d    = (state_q != ST_IDLE);
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_en_d  = acc_en;
                    w_base_d  = w_base;
                    a_base_d  = a_base;
                    p_base_d  = p_base;
                    a_len_d   = a_len;
                    cnt_d     = '0;
                    rd_cnt_d  = '0;
                    wr_cnt_d  = '0;
                    rd_pend_d = 1'b0;
                    state_d   = ST_W_FILL;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            // Read word k from xmem while writing word k-1 (arriving after the
            // 1-cycle SRAM latency) into L0; one extra cycle for the last write.
            ST_W_FILL, ST_A_FILL: begin
                if (cnt_q < fill_len_s) begin
                    inst_d[7]    = 1'b0;
                    inst_d[8]    = 1'b1;
                    inst_d[19:9] = fill_addr_s;
                end else begin
                    inst_d[7]    = 1'b1;
                end
                if (cnt_q != '0) begin
                    inst_d[2] = 1'b1;
                end else begin
                    inst_d[2] = 1'b0;
                end
                if (cnt_q == fill_len_s) begin
                    cnt_d   = '0;
                    state_d = (state_q == ST_W_FILL) ? ST_W_LOAD : ST_A_EXEC;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_W_LOAD: begin
                inst_d[3]   = 1'b1;
                inst_d[1:0] = 2'b01;
                if (cnt_q == CW'(row - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_W_FLUSH;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_W_FLUSH: begin
                if (cnt_q == CW'(col - 1)) begin
                    cnt_d   = '0;
                    state_d = (a_len_q == '0) ? ST_DONE : ST_A_FILL;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_A_EXEC: begin
                inst_d[3]   = 1'b1;
                inst_d[1:0] = 2'b10;
                if (cnt_q == a_len_ext_s - CW'(1)) begin
                    cnt_d   = '0;
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            // FIFO read and the pmem write of the previously read row may overlap.
            ST_DRAIN: begin
                if (ofifo_valid && (rd_cnt_q < a_len_ext_s)) begin
                    inst_d[6] = 1'b1;
                    rd_cnt_d  = rd_cnt_q + CW'(1);
                    rd_pend_d = 1'b1;
                end else begin
                    rd_pend_d = 1'b0;
                end
                if (rd_pend_q) begin
                    inst_d[20]    = 1'b0;
                    inst_d[21]    = 1'b0;
                    inst_d[32:22] = pmem_addr_s;
                    inst_d[33]    = acc_en_q;
                    wr_cnt_d      = wr_cnt_q + CW'(1);
                    if ((wr_cnt_q + CW'(1)) == a_len_ext_s) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else begin
                    wr_cnt_d = wr_cnt_q;
                end
            end

            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter, config and output registers; reset aborts any job.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            rd_pend_q <= 1'b0;
            acc_en_q  <= 1'b0;
            w_base_q  <= '0;
            a_base_q  <= '0;
            p_base_q  <= '0;
            a_len_q   <= '0;
            inst_q    <= IDLE_WORD;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_pend_q <= rd_pend_d;
            acc_en_q  <= acc_en_d;
            w_base_q  <= w_base_d;
            a_base_q  <= a_base_d;
            p_base_q  <= p_base_d;
            a_len_q   <= a_len_d;
            inst_q    <= inst_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_corelet_ctrl.sv
// -----------------------------------------------------------------------------
// tb_corelet_ctrl : scoreboard bench for corelet_ctrl.
// The stimulus process builds the expected per-cycle inst/done stream for each
// job and queues it; a monitor pops one entry per cycle while busy or done is
// high and compares. Hand-written pmem write address lists are checked per job.
// -----------------------------------------------------------------------------
module tb_corelet_ctrl;

    localparam int ROW = 8;
    localparam int COL = 8;
    localparam logic [33:0] IDLE_W = 34'h0100080;

    typedef struct packed {
        logic [33:0] inst;
        logic        done;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic        acc_en;
    logic [10:0] w_base;
    logic [10:0] a_base;
    logic [7:0]  a_len;
    logic [10:0] p_base;
    logic        ofifo_valid;
    logic [33:0] inst;
    logic        busy;
    logic        done;

    exp_t        exp_q[$];
    exp_t        tmp_q[$];
    logic [11:0] wr_log[$];   // {acc, pmem_a} of each observed pmem write
    int          pass_cnt = 0;
    int          total_cnt = 0;

    corelet_ctrl #(.row(ROW), .col(COL), .addr_bw(11), .len_bw(8)) dut (
        .clk(clk), .reset(reset), .start(start), .acc_en(acc_en),
        .w_base(w_base), .a_base(a_base), .a_len(a_len), .p_base(p_base),
        .ofifo_valid(ofifo_valid), .inst(inst), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Monitor: one scoreboard entry per cycle while the DUT reports activity.
    always @(negedge clk) begin
        if (busy === 1'b1 || done === 1'b1) begin
            exp_t e;
            if (inst[20] === 1'b0) wr_log.push_back({inst[33], inst[32:22]});
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_output: got inst=%h done=%b, required no activity", inst, done);
            end else begin
                e = exp_q.pop_front();
                if (inst !== e.inst || done !== e.done)
                    $display("FAIL stream @%0t: got inst=%h done=%b, required inst=%h done=%b",
                             $time, inst, done, e.inst, e.done);
                else
                    pass_cnt++;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total_cnt++;
        if (act !== req) $display("FAIL %s: got %h, required %h", name, act, req);
        else pass_cnt++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic pat_bit(input logic [15:0] pat, input int j);
        return (j < 16) ? pat[j] : 1'b1;
    endfunction

    task automatic push_fill(input logic [10:0] base, input int n);
        exp_t e;
        for (int k = 0; k <= n; k++) begin
            e.inst = IDLE_W;
            e.done = 1'b0;
            if (k < n) begin
                e.inst[7]    = 1'b0;
                e.inst[8]    = 1'b1;
                e.inst[19:9] = base + 11'(k);
            end
            if (k >= 1) e.inst[2] = 1'b1;
            tmp_q.push_back(e);
        end
    endtask

    // Expected inst/done stream, one entry per cycle after the start edge.
    task automatic build(input int alen, input logic [10:0] wb, input logic [10:0] ab,
                         input logic [10:0] pb, input logic acc, input logic [15:0] pat);
        exp_t e;
        int reads, writes;
        logic pend, rd;
        tmp_q.delete();
        push_fill(wb, ROW);
        for (int k = 0; k < ROW; k++) begin
            e.inst = IDLE_W; e.done = 1'b0; e.inst[3] = 1'b1; e.inst[1:0] = 2'b01;
            tmp_q.push_back(e);
        end
        for (int k = 0; k < COL; k++) begin
            e.inst = IDLE_W; e.done = 1'b0;
            tmp_q.push_back(e);
        end
        if (alen != 0) begin
            push_fill(ab, alen);
            for (int k = 0; k < alen; k++) begin
                e.inst = IDLE_W; e.done = 1'b0; e.inst[3] = 1'b1; e.inst[1:0] = 2'b10;
                tmp_q.push_back(e);
            end
            reads = 0; writes = 0; pend = 1'b0;
            for (int j = 0; j < 300; j++) begin
                e.inst = IDLE_W; e.done = 1'b0;
                rd = pat_bit(pat, j) && (reads < alen);
                if (rd) e.inst[6] = 1'b1;
                if (pend) begin
                    e.inst[20] = 1'b0; e.inst[21] = 1'b0;
                    e.inst[32:22] = pb + 11'(writes);
                    e.inst[33] = acc;
                    writes++;
                end
                pend = rd;
                if (rd) reads++;
                tmp_q.push_back(e);
                if (writes == alen) break;
            end
        end
        e.inst = IDLE_W; e.done = 1'b1;
        tmp_q.push_back(e);
    endtask

    // Run one job; abort_at>0 pulls reset low just before that cycle's edge.
    task automatic run(input string tag, input int alen, input logic [10:0] wb,
                       input logic [10:0] ab, input logic [10:0] pb, input logic acc,
                       input logic [15:0] pat, input int abort_at);
        int n, lim, d0;
        build(alen, wb, ab, pb, acc, pat);
        n   = tmp_q.size();
        lim = (abort_at > 0) ? abort_at - 1 : n;
        for (int i = 0; i < lim; i++) exp_q.push_back(tmp_q[i]);
        wr_log.delete();
        d0 = 1 + (ROW + 1) + ROW + COL + (alen + 1) + alen;
        w_base = wb; a_base = ab; a_len = 8'(alen); p_base = pb; acc_en = acc;
        start = 1'b1;
        tick();
        // Config inputs change after the start edge; the job must not notice.
        w_base = 11'h555; a_base = 11'h2aa; a_len = 8'd3; p_base = 11'h123; acc_en = ~acc;
        for (int i = 1; i <= n + 1; i++) begin
            ofifo_valid = (alen != 0 && i >= d0) ? pat_bit(pat, i - d0) : 1'b0;
            start = (i == 5);
            if (i == abort_at) reset = 1'b0;
            tick();
            if (i == abort_at) begin
                reset = 1'b1; start = 1'b0; ofifo_valid = 1'b0;
                chk({tag, "_abort_inst"}, 64'(inst), 64'(IDLE_W));
                chk({tag, "_abort_busy"}, 64'(busy), 64'd0);
                chk({tag, "_abort_done"}, 64'(done), 64'd0);
                break;
            end
        end
        start = 1'b0; ofifo_valid = 1'b0;
        if (abort_at == 0) begin
            chk({tag, "_end_busy"}, 64'(busy), 64'd0);
            chk({tag, "_end_inst"}, 64'(inst), 64'(IDLE_W));
        end
        tick();
        chk({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
        chk({tag, "_idle_done"}, 64'(done), 64'd0);
    endtask

    task automatic chk_writes(input string tag, input logic [11:0] req[4]);
        chk({tag, "_nwrites"}, 64'(wr_log.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            if (i < wr_log.size()) chk({tag, "_write"}, 64'(wr_log[i]), 64'(req[i]));
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; acc_en = 1'b0; w_base = '0; a_base = '0;
        a_len = '0; p_base = '0; ofifo_valid = 1'b0;
        tick();
        tick();
        chk("reset_inst", 64'(inst), 64'(IDLE_W));
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_hold", {29'd0, inst, busy}, {29'd0, IDLE_W, 1'b0});
        end

        run("basic", 4, 11'd0, 11'd16, 11'd100, 1'b0, 16'hffff, 0);
        chk_writes("basic", '{12'd100, 12'd101, 12'd102, 12'd103});

        run("stall", 4, 11'd40, 11'd60, 11'd200, 1'b0, 16'hffd9, 0);
        chk_writes("stall", '{12'd200, 12'd201, 12'd202, 12'd203});

        run("wrap", 4, 11'd2044, 11'd2046, 11'd2046, 1'b1, 16'hffff, 0);
        chk_writes("wrap", '{12'h800 | 12'd2046, 12'h800 | 12'd2047, 12'h800, 12'h801});

        run("zero_len", 0, 11'd5, 11'd9, 11'd77, 1'b1, 16'hffff, 0);
        chk("zero_len_nwrites", 64'(wr_log.size()), 64'd0);

        run("abort", 4, 11'd0, 11'd16, 11'd100, 1'b0, 16'hffff, 32);
        run("after_abort", 4, 11'd0, 11'd16, 11'd100, 1'b0, 16'hffff, 0);
        chk_writes("after_abort", '{12'd100, 12'd101, 12'd102, 12'd103});

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/corelet_ctrl.md
Name: corelet_ctrl

Overview:
- Instruction sequencer that drives the 34-bit `inst` bus of the corelet.
- It is the initiator side of the corelet protocol:
  - streams weights and then activations from xmem into L0,
  - issues the kernel-load and execute MAC opcodes,
  - drains the output FIFO into pmem.
- Sits between the testbench/top-level start handshake and the corelet + xmem/pmem SRAMs.

Parameters:
- row, 8, PE rows; number of weight words loaded per kernel.
- col, 8, PE columns; flush cycles after kernel load.
- addr_bw, 11, SRAM address width (xmem and pmem).
- len_bw, 8, width of activation-length field.

Ports:
- clk  input  1  clock; all logic on posedge.
- reset  input  1  synchronous, active-low reset (reset=0 at posedge resets).
- start  input  1  one-cycle request; sampled only in IDLE.
- acc_en  input  1  latched at start; drives inst[33] during pmem writes.
- w_base  input  addr_bw  xmem base address of weights; latched at start.
- a_base  input  addr_bw  xmem base address of activations; latched at start.
- a_len  input  len_bw  number of activation vectors (0..L0 depth); latched at start.
- p_base  input  addr_bw  pmem base address for psums; latched at start.
- ofifo_valid  input  1  corelet output FIFO has a readable row.
- inst  output  34  registered corelet/SRAM instruction word.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse on completion.

Behaviour:
- inst field map (fixed):
  - [1:0] inst_w: 00 nop, 01 kernel load, 10 execute.
  - [2] l0_wr. [3] l0_rd. [5:4] reserved, always 0. [6] ofifo_rd.
  - [7] xmem_cen (active low). [8] xmem_wen (active low). [19:9] xmem_a.
  - [20] pmem_cen (active low). [21] pmem_wen (active low). [32:22] pmem_a.
  - [33] acc.
- Idle word: 34'h0100080 (both CEN high, all else 0). The reset value of inst is the idle word.
- Reset: state=IDLE, counters=0, busy=0, done=0. Reset mid-operation aborts immediately; the next cycle inst is the idle word.
- All outputs are registered: inst reflects the state of the previous cycle's decision.
- SRAM read latency is 1 cycle. L0 write is asserted one cycle after the matching xmem read.
- States and transitions:
  - IDLE: start=1 → latch config, go W_FILL. start in any other state is ignored.
  - W_FILL: row+1 cycles, k=0..row.
    - k<row: xmem_cen=0, xmem_wen=1, xmem_a=w_base+k.
    - k≥1: l0_wr=1.
    - Then go W_LOAD.
  - W_LOAD: row cycles, l0_rd=1, inst_w=01. Then go W_FLUSH.
  - W_FLUSH: col cycles, inst_w=00.
    - a_len=0 → go DONE.
    - Otherwise go A_FILL.
  - A_FILL: a_len+1 cycles, same pattern as W_FILL with a_base and a_len. Then go A_EXEC.
  - A_EXEC: a_len cycles, l0_rd=1, inst_w=10. Then go DRAIN.
  - DRAIN:
    - Each cycle with ofifo_valid=1 and reads_issued<a_len: ofifo_rd=1, reads_issued+1.
    - One cycle after each ofifo_rd: pmem_cen=0, pmem_wen=0, pmem_a=p_base+writes_done, acc=acc_en; then writes_done+1.
    - ofifo_rd and a pmem write may occur in the same cycle (back-to-back streaming).
    - Leave when writes_done==a_len → go DONE.
    - No timeout.
  - DONE: 1 cycle, done=1, inst=idle word. Then go IDLE; busy drops the cycle after done.
- Arithmetic: address sums are addr_bw bits, modulo 2^addr_bw (wrap at 2047→0). Counters are len_bw+1 bits wide.
- acc (inst[33]) is 0 everywhere except DRAIN pmem write cycles when acc_en=1.
- Reserved bits [5:4] are always 0.

Test Plan:
- Reset then idle: reset=0 for 2 cycles → inst=34'h0100080, busy=0, done=0; holds while start=0.
- Basic run: w_base=0, a_base=16, a_len=4, p_base=100, acc_en=0, start pulse; model raises ofifo_valid during DRAIN.
  - xmem_a 0..7 with l0_wr lagging by 1 cycle.
  - 8 cycles of inst_w=01, then 8 flush cycles.
  - xmem_a 16..19, then 4 cycles of inst_w=10.
  - pmem writes at 100..103 with acc=0; done asserted exactly once.
- Drain stall: ofifo_valid toggles 1,0,0,1,1,0,1 → ofifo_rd only on valid cycles; exactly 4 pmem writes, each 1 cycle after its read; no write when the FIFO is empty.
- Wrap and accumulate: p_base=2046, a_len=4, acc_en=1 → pmem_a 2046, 2047, 0, 1 with inst[33]=1 only on those write cycles.
- Edge cases:
  - a_len=0 → sequence ends W_FLUSH→DONE with no A_FILL/EXEC/DRAIN activity.
  - start asserted while busy → ignored; latched config unchanged.
- Reset mid-A_EXEC: reset=0 for one cycle → next inst is the idle word, busy=0, no done pulse; a new start then runs a full sequence correctly.
